orion_merge_arb: RTL and testbench

//  Clocked arbiter/sequencer that feeds two synchronous valid/ready sources into the
//  A/B 2-phase bundled-data inputs of an orion merge element. The merge has no mutual

---
 rtl/orion_merge_arb.sv | 111 +++++++++++
 tb/tb_orion_merge_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/orion_merge_arb.sv
// Feeds two valid/ready sources into the 2-phase A/B inputs of an orion merge, one token in flight.
// Req edge 1 clk after accept, idle SYNC_STAGES+1 clk after the ack edge; both readys low while a token is out.
module orion_merge_arb #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit PA_INIT     = 1'b0,
  parameter bit PB_INIT     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             inA_req,
  input  logic             inA_ack,
  output logic [WIDTH-1:0] inA_data,
  output logic             inB_req,
  input  logic             inB_ack,
  output logic [WIDTH-1:0] inB_data,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t                 state, state_nxt;
  logic                   sel, last_grant;
  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic                   a_ack_s, b_ack_s;
  logic                   a_ack_chg, b_ack_chg;
  logic                   win_a, win_b;
  logic                   a_ack_ok, b_ack_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync <= {SYNC_STAGES{PA_INIT}};
      b_sync <= {SYNC_STAGES{PB_INIT}};
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], inA_ack};
      b_sync <= {b_sync[SYNC_STAGES-2:0], inB_ack};
    end
  end

  assign a_ack_s = a_sync[SYNC_STAGES-1];
  assign b_ack_s = b_sync[SYNC_STAGES-1];
  // Change is seen one stage early so err lands exactly SYNC_STAGES clocks after the ack edge.
  assign a_ack_chg = a_sync[SYNC_STAGES-1] ^ a_sync[SYNC_STAGES-2];
  assign b_ack_chg = b_sync[SYNC_STAGES-1] ^ b_sync[SYNC_STAGES-2];

  assign win_a = a_valid & (~b_valid | (last_grant == GRANT_B));
  assign win_b = b_valid & (~a_valid | (last_grant == GRANT_A));

  assign a_ready = reset_n & (state == IDLE) & win_a;
  assign b_ready = reset_n & (state == IDLE) & win_b;
  assign busy    = (state != IDLE);

  assign a_ack_ok = (state == WAIT) & (sel == GRANT_A);
  assign b_ack_ok = (state == WAIT) & (sel == GRANT_B);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_ready | b_ready) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (sel == GRANT_A) begin
          if (a_ack_s == inA_req) state_nxt = IDLE;
        end else begin
          if (b_ack_s == inB_req) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= GRANT_B;
      last_grant <= GRANT_B;
      inA_req    <= PA_INIT;
      inB_req    <= PB_INIT;
      inA_data   <= '0;
      inB_data   <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (a_ready) begin
        inA_data   <= a_data;
        sel        <= GRANT_A;
        last_grant <= GRANT_A;
      end else if (b_ready) begin
        inB_data   <= b_data;
        sel        <= GRANT_B;
        last_grant <= GRANT_B;
      end
      // Data was registered on accept, so it already had a full clock of setup before this edge.
      if (state == ISSUE) begin
        if (sel == GRANT_A) inA_req <= ~inA_req;
        else                inB_req <= ~inB_req;
      end
      err <= err | (a_ack_chg & ~a_ack_ok) | (b_ack_chg & ~b_ack_ok);
    end
  end

endmodule

// File: tb/tb_orion_merge_arb.sv
// Directed bench for orion_merge_arb with a looped-back merge responder and a grant scoreboard.
module tb_orion_merge_arb;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [W-1:0] a_data, b_data;
  logic         inA_req, inA_ack, inB_req, inB_ack;
  logic [W-1:0] inA_data, inB_data;
  logic         busy, err;

  orion_merge_arb #(.WIDTH(W), .SYNC_STAGES(SS), .PA_INIT(1'b0), .PB_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .inA_req(inA_req), .inA_ack(inA_ack), .inA_data(inA_data),
    .inB_req(inB_req), .inB_ack(inB_ack), .inB_data(inB_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic ch; logic [W-1:0] d; } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] qa[$], qb[$];
  int           checks = 0, errors = 0;

  logic         s_a_ready, s_b_ready, s_busy, s_err, s_a_req, s_b_req, s_a_ack, s_b_ack;
  logic [W-1:0] s_a_data, s_b_data, hold_a, hold_b, junk;
  logic         pa, pb, rpa, rpb, xa, xb;
  int           cnt_a, cnt_b, na, nb;
  bit           b_rdy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_pop(input logic ch, input logic [W-1:0] d);
    exp_t e;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant_ch", 32'(ch), 32'(e.ch));
      chk("grant_data", 32'(d), 32'(e.d));
    end
  endtask

  // One clock: drive sources and merge model at posedge+1, sample and score at negedge.
  task automatic step();
    if (qa.size() > 0) begin a_valid = 1'b1; a_data = qa[0]; end
    else begin a_valid = 1'b0; a_data = '0; end
    if (qb.size() > 0) begin b_valid = 1'b1; b_data = qb[0]; end
    else begin b_valid = 1'b0; b_data = '0; end
    if (!reset_n) begin
      inA_ack = 1'b0; inB_ack = 1'b0; rpa = 1'b0; rpb = 1'b0; cnt_a = 0; cnt_b = 0;
    end else begin
      if (inA_req !== rpa) begin rpa = inA_req; cnt_a = 1; end
      else if (cnt_a > 0) begin
        cnt_a++;
        if (cnt_a >= 3) begin inA_ack = rpa; cnt_a = 0; end
      end
      if (inB_req !== rpb) begin rpb = inB_req; cnt_b = 1; end
      else if (cnt_b > 0) begin
        cnt_b++;
        if (cnt_b >= 3) begin inB_ack = rpb; cnt_b = 0; end
      end
    end
    @(negedge clk);
    s_a_ready = a_ready; s_b_ready = b_ready; s_busy = busy; s_err = err;
    s_a_req = inA_req; s_b_req = inB_req; s_a_ack = inA_ack; s_b_ack = inB_ack;
    s_a_data = inA_data; s_b_data = inB_data;
    xa = a_valid & a_ready;
    xb = b_valid & b_ready;
    if (b_ready) b_rdy_seen = 1'b1;
    if (!reset_n) begin
      pa = inA_req; pb = inB_req;
    end else begin
      chk("one_outstanding", 32'((inA_req ^ inA_ack) & (inB_req ^ inB_ack)), 0);
      if (inA_req !== pa) begin
        pa = inA_req; na++; hold_a = inA_data; sb_pop(1'b0, inA_data);
      end else if (inA_req !== inA_ack) chk("a_data_stable", 32'(inA_data), 32'(hold_a));
      if (inB_req !== pb) begin
        pb = inB_req; nb++; hold_b = inB_data; sb_pop(1'b1, inB_data);
      end else if (inB_req !== inB_ack) chk("b_data_stable", 32'(inB_data), 32'(hold_b));
    end
    @(posedge clk);
    #1;
    if (xa) junk = qa.pop_front();
    if (xb) junk = qb.pop_front();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((qa.size() != 0 || qb.size() != 0 || exp_q.size() != 0 || s_busy) && n < 400);
    chk(tag, 32'(qa.size() + qb.size() + exp_q.size()) + 32'(s_busy), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    inA_ack = 1'b0; inB_ack = 1'b0; pa = 1'b0; pb = 1'b0; rpa = 1'b0; rpb = 1'b0;
    cnt_a = 0; cnt_b = 0; na = 0; nb = 0; b_rdy_seen = 1'b0; hold_a = '0; hold_b = '0;
    junk = '0;

    // 1: reset values
    step();
    step();
    chk("rst_a_req", 32'(s_a_req), 0);
    chk("rst_b_req", 32'(s_b_req), 0);
    chk("rst_a_data", 32'(s_a_data), 0);
    chk("rst_b_data", 32'(s_b_data), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_err", 32'(s_err), 0);
    chk("rst_readys", 32'({s_a_ready, s_b_ready}), 0);
    reset_n = 1'b1;

    // 2: single A word, cycle-exact
    qa.push_back(8'h01);
    exp_q.push_back({1'b0, 8'h01});
    step();
    chk("t2_a_ready", 32'(s_a_ready), 1);
    chk("t2_b_ready", 32'(s_b_ready), 0);
    chk("t2_busy_idle", 32'(s_busy), 0);
    step();
    chk("t2_a_ready_drop", 32'(s_a_ready), 0);
    chk("t2_busy_issue", 32'(s_busy), 1);
    chk("t2_a_data", 32'(s_a_data), 32'h01);
    chk("t2_req_not_yet", 32'(s_a_req), 0);
    step();
    chk("t2_req_edge", 32'(s_a_req), 1);
    chk("t2_b_req", 32'(s_b_req), 0);
    chk("t2_b_data", 32'(s_b_data), 0);
    n = 0;
    while (!s_a_ack && n < 20) begin step(); n++; end
    chk("t2_ack_seen", 32'(s_a_ack), 1);
    n = 0;
    do begin step(); n++; end while (s_busy && n < 20);
    chk("t2_idle_latency", 32'(n), 32'(SS + 1));

    // 3: contention, alternation starting with A after reset
    do_reset();
    na = 0; nb = 0;
    qa.push_back(8'h20); qa.push_back(8'h22);
    qb.push_back(8'h21); qb.push_back(8'h23);
    exp_q.push_back({1'b0, 8'h20}); exp_q.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h23});
    drain("t3_drain");
    chk("t3_a_edges", 32'(na), 2);
    chk("t3_b_edges", 32'(nb), 2);

    // 4: back-to-back A only
    na = 0; nb = 0; b_rdy_seen = 1'b0;
    qa.push_back(8'h10); qa.push_back(8'h11); qa.push_back(8'h12);
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h12});
    drain("t4_drain");
    chk("t4_a_edges", 32'(na), 3);
    chk("t4_b_edges", 32'(nb), 0);
    chk("t4_b_ready_low", 32'(b_rdy_seen), 0);

    // 5: stray ack on B while idle
    na = 0; nb = 0;
    inB_ack = ~inB_ack;
    step();
    chk("t5_err_c0", 32'(s_err), 0);
    step();
    chk("t5_err_c1", 32'(s_err), 0);
    step();
    chk("t5_err_set", 32'(s_err), 1);
    inB_ack = ~inB_ack;
    repeat (4) step();
    chk("t5_err_sticky", 32'(s_err), 1);
    chk("t5_no_req_a", 32'(na), 0);
    chk("t5_no_req_b", 32'(nb), 0);
    chk("t5_busy", 32'(s_busy), 0);

    // 6: reset while waiting for the ack
    do_reset();
    chk("t6_err_cleared", 32'(s_err), 0);
    qa.push_back(8'h55);
    exp_q.push_back({1'b0, 8'h55});
    n = 0;
    do begin step(); n++; end while (!s_a_req && n < 10);
    chk("t6_req_out", 32'(s_a_req), 1);
    step();
    reset_n = 1'b0;
    qa.push_back(8'h66);
    step();
    chk("t6_rst_a_req", 32'(s_a_req), 0);
    chk("t6_rst_a_data", 32'(s_a_data), 0);
    chk("t6_rst_busy", 32'(s_busy), 0);
    chk("t6_rst_a_ready", 32'(s_a_ready), 0);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    step();
    reset_n = 1'b1;
    na = 0;
    exp_q.push_back({1'b0, 8'h66});
    drain("t6_drain");
    chk("t6_a_edges", 32'(na), 1);
    chk("t6_err", 32'(s_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
